shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Serial transfer sequencer: streams a parallel word into an external DEPTH-stage
// shift register and reassembles the word returning on its serial output.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             abort,
    input  logic             sr_dout,
    output logic             sr_din,
    output logic             sr_l,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data
);

    localparam int CW = $clog2(WIDTH + DEPTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] DEP  = CW'(DEPTH);
    localparam logic [CW-1:0] WID  = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    rx_pos;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] lsb_one;
    logic [WIDTH-1:0] msb_one;
    logic             dir_q;

    // Bit k in transmission order; shifting avoids a variable-width part select.
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic d,
                                  input logic [CW-1:0] k);
        logic [WIDTH-1:0] t;
        if (d) begin
            t = w << k;
            return t[WIDTH-1];
        end
        t = w >> k;
        return t[0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT: begin
                if (abort)             state_nxt = IDLE;
                else if (cnt == LAST)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cnt_nxt = cnt + 1'b1;
    assign rx_pos  = cnt - DEP;
    assign lsb_one = {{(WIDTH-1){1'b0}}, sr_dout};
    assign msb_one = {sr_dout, {(WIDTH-1){1'b0}}};

    // Received bit j lands where transmit bit j was taken from.
    always_comb begin
        acc_nxt = acc;
        if (cnt >= DEP)
            acc_nxt = acc | (dir_q ? (msb_one >> rx_pos) : (lsb_one << rx_pos));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            word    <= '0;
            acc     <= '0;
            dir_q   <= 1'b0;
            sr_din  <= 1'b0;
            rx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sr_din <= 1'b0;
                    if (start) begin
                        word   <= tx_data;
                        dir_q  <= dir;
                        cnt    <= '0;
                        acc    <= '0;
                        sr_din <= pick(tx_data, dir, '0);
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        sr_din <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt == LAST) begin
                        rx_data <= acc_nxt;
                        sr_din  <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        acc    <= acc_nxt;
                        cnt    <= cnt_nxt;
                        sr_din <= (cnt_nxt < WID) ? pick(word, dir_q, cnt_nxt) : 1'b0;
                    end
                end
                default: sr_din <= 1'b0;
            endcase
        end
    end

    assign sr_l = dir_q;
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 4-stage delay line as the shift register.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       abort = 1'b0;
    logic       sr_dout;
    logic       sr_din;
    logic       sr_l;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    logic [3:0] dl = '0;
    int tests = 0;
    int fails = 0;

    shift_seq_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .tx_data(tx_data),
        .abort(abort), .sr_dout(sr_dout), .sr_din(sr_din), .sr_l(sr_l),
        .busy(busy), .done(done), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dl <= {dl[2:0], sr_din};
    assign sr_dout = dl[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transfer and observes 16 cycles after the start edge.
    task automatic run_xfer(input logic [7:0] d, input logic dr, input logic ab0,
                            input int abort_at, input int rst_at, input int sp1, input int sp2,
                            output logic [11:0] seq, output int nbusy, output int ndone,
                            output int first_done, output int nboth, output logic [11:0] snap);
        tx_data = d; dir = dr; start = 1'b1; abort = ab0;
        step();
        start = 1'b0; abort = 1'b0; tx_data = 8'h00; dir = ~dr;
        seq = '0; nbusy = 0; ndone = 0; first_done = -1; nboth = 0; snap = '1;
        for (int c = 0; c < 16; c++) begin
            if (c < 12) seq = {sr_din, seq[11:1]};
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (busy && done) nboth++;
            if (c == rst_at + 1) snap = {busy, done, sr_din, sr_l, rx_data};
            reset = (c == rst_at);
            abort = (c == abort_at);
            start = (c == sp1) || (c == sp2);
            tx_data = start ? ~d : 8'h00;
            step();
        end
        reset = 1'b0; abort = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b1; tx_data = 8'hFF; dir = 1'b1;
        step(); step();
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL rst_done: got %b want 0", done); end
        tests++; if (sr_din !== 1'b0)  begin fails++; $display("FAIL rst_sr_din: got %b want 0", sr_din); end
        tests++; if (sr_l !== 1'b0)    begin fails++; $display("FAIL rst_sr_l: got %b want 0", sr_l); end
        tests++; if (rx_data !== 8'h0) begin fails++; $display("FAIL rst_rx: got %h want 00", rx_data); end
        reset = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0;
        step(); step();
    endtask

    task automatic test_lsb_first();
        logic [11:0] seq, snap; int nb, nd, fd, nboth;
        run_xfer(8'hA5, 1'b0, 1'b0, -1, -10, -1, -1, seq, nb, nd, fd, nboth, snap);
        tests++; if (seq !== 12'h0A5) begin fails++; $display("FAIL a5_seq: got %h want 0a5", seq); end
        tests++; if (nb != 12)  begin fails++; $display("FAIL a5_busy_cycles: got %0d want 12", nb); end
        tests++; if (fd != 12 || nd != 1) begin fails++; $display("FAIL a5_done: at %0d x%0d want at 12 x1", fd, nd); end
        tests++; if (nboth != 0) begin fails++; $display("FAIL a5_busy_done_overlap: got %0d want 0", nboth); end
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL a5_rx: got %h want a5", rx_data); end
        tests++; if (sr_l !== 1'b0) begin fails++; $display("FAIL a5_sr_l: got %b want 0", sr_l); end
    endtask

    task automatic test_msb_first();
        logic [11:0] seq, snap; int nb, nd, fd, nboth;
        run_xfer(8'h3C, 1'b1, 1'b0, -1, -10, -1, -1, seq, nb, nd, fd, nboth, snap);
        tests++; if (seq !== 12'h03C) begin fails++; $display("FAIL 3c_seq: got %h want 03c", seq); end
        tests++; if (fd != 12 || nd != 1) begin fails++; $display("FAIL 3c_done: at %0d x%0d want at 12 x1", fd, nd); end
        tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL 3c_rx: got %h want 3c", rx_data); end
        tests++; if (sr_l !== 1'b1) begin fails++; $display("FAIL 3c_sr_l_held: got %b want 1", sr_l); end
    endtask

    task automatic test_msb_asym();
        logic [11:0] seq, snap; int nb, nd, fd, nboth;
        run_xfer(8'h01, 1'b1, 1'b0, -1, -10, -1, -1, seq, nb, nd, fd, nboth, snap);
        tests++; if (seq !== 12'h080) begin fails++; $display("FAIL 01_msb_seq: got %h want 080", seq); end
        tests++; if (rx_data !== 8'h01) begin fails++; $display("FAIL 01_msb_rx: got %h want 01", rx_data); end
        run_xfer(8'h3C, 1'b1, 1'b0, -1, -10, -1, -1, seq, nb, nd, fd, nboth, snap);
    endtask

    task automatic test_abort();
        logic [11:0] seq, snap; int nb, nd, fd, nboth;
        run_xfer(8'hFF, 1'b0, 1'b0, 4, -10, -1, -1, seq, nb, nd, fd, nboth, snap);
        tests++; if (nb != 5)  begin fails++; $display("FAIL abort_busy_cycles: got %0d want 5", nb); end
        tests++; if (nd != 0)  begin fails++; $display("FAIL abort_done: got %0d want 0", nd); end
        tests++; if (seq !== 12'h01F) begin fails++; $display("FAIL abort_seq: got %h want 01f", seq); end
        tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL abort_rx_kept: got %h want 3c", rx_data); end
        run_xfer(8'h81, 1'b0, 1'b0, -1, -10, -1, -1, seq, nb, nd, fd, nboth, snap);
        tests++; if (fd != 12 || nd != 1) begin fails++; $display("FAIL post_abort_done: at %0d x%0d want at 12 x1", fd, nd); end
        tests++; if (rx_data !== 8'h81) begin fails++; $display("FAIL post_abort_rx: got %h want 81", rx_data); end
    endtask

    task automatic test_start_ignored();
        logic [11:0] seq, snap; int nb, nd, fd, nboth;
        run_xfer(8'h5A, 1'b0, 1'b0, -1, -10, 3, 12, seq, nb, nd, fd, nboth, snap);
        tests++; if (nd != 1)  begin fails++; $display("FAIL ign_done_count: got %0d want 1", nd); end
        tests++; if (nb != 12) begin fails++; $display("FAIL ign_busy_cycles: got %0d want 12", nb); end
        tests++; if (seq !== 12'h05A) begin fails++; $display("FAIL ign_seq: got %h want 05a", seq); end
        tests++; if (rx_data !== 8'h5A) begin fails++; $display("FAIL ign_rx: got %h want 5a", rx_data); end
        tests++; if (sr_l !== 1'b0) begin fails++; $display("FAIL ign_sr_l: got %b want 0", sr_l); end
    endtask

    task automatic test_reset_mid_shift();
        logic [11:0] seq, snap; int nb, nd, fd, nboth;
        run_xfer(8'hC3, 1'b1, 1'b0, -1, 6, -1, -1, seq, nb, nd, fd, nboth, snap);
        tests++; if (snap !== 12'h000) begin fails++; $display("FAIL midrst_outputs: got %h want 000", snap); end
        tests++; if (nd != 0)  begin fails++; $display("FAIL midrst_done: got %0d want 0", nd); end
        tests++; if (nb != 7)  begin fails++; $display("FAIL midrst_busy_cycles: got %0d want 7", nb); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL midrst_rx: got %h want 00", rx_data); end
        run_xfer(8'h96, 1'b0, 1'b1, -1, -10, -1, -1, seq, nb, nd, fd, nboth, snap);
        tests++; if (nb != 12) begin fails++; $display("FAIL start_abort_busy: got %0d want 12", nb); end
        tests++; if (fd != 12 || nd != 1) begin fails++; $display("FAIL start_abort_done: at %0d x%0d want at 12 x1", fd, nd); end
        tests++; if (rx_data !== 8'h96) begin fails++; $display("FAIL start_abort_rx: got %h want 96", rx_data); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] seq, snap; int nb, nd, fd, nboth;
        run_xfer(8'hE7, 1'b0, 1'b0, -1, -10, 13, -1, seq, nb, nd, fd, nboth, snap);
        tests++; if (rx_data !== 8'hE7) begin fails++; $display("FAIL b2b_first_rx: got %h want e7", rx_data); end
        tests++; if (!busy) begin fails++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        repeat (20) step();
        tests++; if (rx_data !== 8'h18) begin fails++; $display("FAIL b2b_second_rx: got %h want 18", rx_data); end
        tests++; if (sr_l !== 1'b1) begin fails++; $display("FAIL b2b_second_sr_l: got %b want 1", sr_l); end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_msb_asym();
        test_abort();
        test_start_ignored();
        test_reset_mid_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
